// File: rtl/queue_pkg.sv
// Shared definitions for the queue read-side controller.
// Contents: default queue geometry, controller state enum, skid-buffer occupancy width.
package queue_pkg;

    localparam int unsigned ADDR_DEF      = 5;
    localparam int unsigned DATA_DEF      = 42;
    localparam int unsigned Q_SIZE_DEF    = 32;
    localparam int unsigned BURST_LEN_DEF = 8;

    // Skid buffer holds 0..2 words.
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/queue_reader_if.sv
// Bundle of the queue read port and the downstream valid/ready stream.
// master: the reader (drives q_ren, out_data, out_valid).
// slave : the queue plus stream sink (drives q_rdata, q_empty, q_count, out_ready).
interface queue_reader_if
    import queue_pkg::*;
#(
    parameter int unsigned ADDR = ADDR_DEF,
    parameter int unsigned DATA = DATA_DEF
) ();

    logic [DATA-1:0] q_rdata;
    logic            q_empty;
    logic [ADDR:0]   q_count;
    logic            q_ren;
    logic [DATA-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        input  q_rdata, q_empty, q_count, out_ready,
        output q_ren, out_data, out_valid
    );

    modport slave (
        output q_rdata, q_empty, q_count, out_ready,
        input  q_ren, out_data, out_valid
    );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry FIFO between the queue pop and the output stream.
// Ports: clk, rst_n (async active-low); push/push_data write side;
// pop removes the head; occ is current fill (0..2); out_valid/out_data expose the head.
module skid_buf2
    import queue_pkg::*;
#(
    parameter int unsigned DATA = DATA_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DATA-1:0]  push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic             out_valid,
    output logic [DATA-1:0]  out_data
);

    logic [DATA-1:0]  ent0_q, ent0_d;  // head
    logic [DATA-1:0]  ent1_q, ent1_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop && (occ_q != '0);
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
        case (occ_q)
            2'd0: begin
                if (push_ok) ent0_d = push_data;
            end
            2'd1: begin
                // Pop and push together: new word becomes the head directly.
                if (push_ok && pop_ok) ent0_d = push_data;
                else if (push_ok)      ent1_d = push_data;
            end
            default: begin
                if (pop_ok) begin
                    ent0_d = ent1_q;
                    if (push_ok) ent1_d = push_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign out_valid = (occ_q != '0);
    assign out_data  = ent0_q;

endmodule

// File: rtl/queue_reader.sv
// Read-side controller for the circular queue: pops in BURST_LEN bursts once enough
// words are queued, or drains completely on flush, feeding a valid/ready stream
// through a 2-entry skid buffer.
// Ports: clk, rst_n (async active-low); bus (queue read port + output stream, master);
// flush (single-cycle drain request); busy (controller not IDLE).
// Optional macro QUEUE_READER_STATS_EN adds pop_count[31:0] (saturating) and
// burst_count[15:0] (wrapping).
module queue_reader
    import queue_pkg::*;
#(
    parameter int unsigned ADDR      = ADDR_DEF,
    parameter int unsigned DATA      = DATA_DEF,
    parameter int unsigned Q_SIZE    = Q_SIZE_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    queue_reader_if.master        bus,
    input  logic                  flush,
    output logic                  busy
`ifdef QUEUE_READER_STATS_EN
    ,
    output logic [31:0]           pop_count,
    output logic [15:0]           burst_count
`endif
);

    // Out-of-range burst lengths are clamped into 1..Q_SIZE.
    localparam int unsigned BURST_EFF = (BURST_LEN == 0) ? 1 :
                                        (BURST_LEN > Q_SIZE) ? Q_SIZE : BURST_LEN;
    localparam logic [ADDR:0] BURST_W = BURST_EFF[ADDR:0];

    state_e           state_q, state_d;
    logic [ADDR:0]    beats_q, beats_d;
    logic             pend_q, pend_d;
    logic [OCC_W-1:0] occ;
    logic             pop, xfer, last_beat;

    assign xfer = bus.out_valid && bus.out_ready;

    // Depends only on registered state/occ and queue outputs, never on out_ready.
    assign pop = (state_q != IDLE) && !bus.q_empty && (occ < 2'd2) &&
                 ((state_q != BURST) || (beats_q != '0));
    assign bus.q_ren = pop;

    assign last_beat = (state_q == BURST) && pop && (beats_q == ADDR'(1) + '0);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (flush || pend_q) begin
                    state_d = FLUSH;
                    pend_d  = 1'b0;
                end else if (bus.q_count >= BURST_W) begin
                    state_d = BURST;
                    beats_d = BURST_W;
                end
            end
            BURST: begin
                if (pop)       beats_d = beats_q - 1'b1;
                if (last_beat) state_d = IDLE;
                if (flush)     pend_d  = 1'b1;
            end
            FLUSH: begin
                if (bus.q_empty && !pop) state_d = IDLE;
                if (flush)               pend_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beats_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            pend_q  <= pend_d;
        end
    end

    skid_buf2 #(
        .DATA (DATA)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pop),
        .push_data (bus.q_rdata),
        .pop       (xfer),
        .occ       (occ),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data)
    );

`ifdef QUEUE_READER_STATS_EN
    logic [31:0] pop_cnt_q;
    logic [15:0] burst_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (pop && (pop_cnt_q != '1)) pop_cnt_q <= pop_cnt_q + 32'd1;
            if (last_beat)                burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end

    assign pop_count   = pop_cnt_q;
    assign burst_count = burst_cnt_q;
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: the bench plays the circular queue and the stream sink,
// and predicts the controller from its rules using SV queues.
module tb_queue_reader;
    import queue_pkg::*;

    localparam int unsigned ADDR   = 5;
    localparam int unsigned DATA   = 42;
    localparam int unsigned Q_SIZE = 32;
    localparam int unsigned BL     = 4;
    localparam int M_IDLE = 0, M_BURST = 1, M_FLUSH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef QUEUE_READER_STATS_EN
    logic [31:0] pop_count;
    logic [15:0] burst_count;
`endif

    queue_reader_if #(.ADDR(ADDR), .DATA(DATA)) bus ();

    queue_reader #(
        .ADDR      (ADDR),
        .DATA      (DATA),
        .Q_SIZE    (Q_SIZE),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .busy        (busy)
`ifdef QUEUE_READER_STATS_EN
        ,
        .pop_count   (pop_count),
        .burst_count (burst_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA-1:0] qm[$];   // queue contents, head first
    logic [DATA-1:0] sk[$];   // words expected to sit in the skid buffer
    logic [DATA-1:0] got[$];  // words accepted by the sink
    logic [DATA-1:0] w[6];
    int m_st, m_beats, m_pops, m_bursts;
    bit m_pend;
    int n_vec = 0, n_err = 0;
    int tb_pops = 0;
    int base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_st = M_IDLE; m_beats = 0; m_pend = 0; m_pops = 0; m_bursts = 0;
        sk.delete();
    endtask

    task automatic drive_q();
        bus.q_rdata = (qm.size() != 0) ? qm[0] : '0;
        bus.q_empty = (qm.size() == 0);
        bus.q_count = (ADDR + 1)'(qm.size());
    endtask

    task automatic load(input logic [DATA-1:0] d);
        if (qm.size() < Q_SIZE) qm.push_back(d);
    endtask

    // One clock: drive at negedge, check mid-low-phase, advance model after posedge.
    task automatic step(input bit fl, input bit rdy, input int npush);
        bit exp_ren, xf, act_ren;
        int qc;
        @(negedge clk);
        flush = fl;
        bus.out_ready = rdy;
        drive_q();
        #2;
        qc = qm.size();
        exp_ren = rst_n && (m_st != M_IDLE) && (qc != 0) && (sk.size() < 2) &&
                  ((m_st != M_BURST) || (m_beats != 0));
        xf = (sk.size() != 0) && rdy;
        chk("q_ren", 64'(bus.q_ren), 64'(exp_ren));
        chk("out_valid", 64'(bus.out_valid), 64'(sk.size() != 0));
        if (sk.size() != 0) chk("out_data", 64'(bus.out_data), 64'(sk[0]));
        chk("busy", 64'(busy), 64'(m_st != M_IDLE));
`ifdef QUEUE_READER_STATS_EN
        chk("pop_count", 64'(pop_count), 64'(m_pops));
        chk("burst_count", 64'(burst_count), 64'(m_bursts));
`endif
        act_ren = bus.q_ren;
        if (bus.out_valid && rdy) got.push_back(bus.out_data);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            reset_model();
        end else begin
            if (xf) void'(sk.pop_front());
            if (exp_ren) begin
                sk.push_back(qm[0]);
                m_pops++;
            end
            case (m_st)
                M_IDLE: begin
                    if (fl || m_pend) begin
                        m_st = M_FLUSH; m_pend = 0;
                    end else if (qc >= BL) begin
                        m_st = M_BURST; m_beats = BL;
                    end
                end
                M_BURST: begin
                    if (exp_ren) m_beats--;
                    if (exp_ren && m_beats == 0) begin
                        m_st = M_IDLE; m_bursts++;
                    end
                    if (fl) m_pend = 1;
                end
                default: begin
                    if (qc == 0) m_st = M_IDLE;
                    if (fl) m_pend = 1;
                end
            endcase
        end
        if (act_ren && qm.size() != 0) begin
            void'(qm.pop_front());
            tb_pops++;
        end
        for (int i = 0; i < npush; i++) load(DATA'({$urandom(), $urandom()}));
    endtask

    initial begin
        reset_model();
        bus.out_ready = 1'b0;
        drive_q();

        // Reset held with words queued: everything quiet.
        load(42'hA); load(42'hB); load(42'hC);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Three words below burst length: no pops; fourth word starts a burst.
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        chk("below_burst_pops", 64'(tb_pops), 64'h0);
        load(42'hD);
        got.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        chk("burst_drained", 64'(qm.size()), 64'h0);
        chk("burst_n", 64'(got.size()), 64'h4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("burst_order", 64'(got[i]), 64'(42'hA + 42'(i)));

        // Backpressure: only two pops fit, head word held.
        got.delete();
        base = tb_pops;
        for (int i = 0; i < 4; i++) begin
            w[i] = DATA'({$urandom(), $urandom()});
            load(w[i]);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("bp_pops", 64'(tb_pops - base), 64'h2);
        chk("bp_hold_data", 64'(bus.out_data), 64'(w[0]));
        chk("bp_hold_valid", 64'(bus.out_valid), 64'h1);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        chk("bp_n", 64'(got.size()), 64'h4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("bp_order", 64'(got[i]), 64'(w[i]));

        // Flush below burst length, flush on empty, flush during a burst.
        load(42'h111); load(42'h222);
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("flush_drained", 64'(qm.size()), 64'h0);
        step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 5; i++) load(42'h300 + 42'(i));
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        chk("flush_in_burst_drained", 64'(qm.size()), 64'h0);

        // Asynchronous reset after two pops of a burst.
        for (int i = 0; i < 4; i++) begin
            w[i] = DATA'({$urandom(), $urandom()});
            load(w[i]);
        end
        base = tb_pops;
        for (int i = 0; i < 10 && (tb_pops - base) < 2; i++) step(0, 1, 0);
        chk("pre_rst_pops", 64'(tb_pops - base), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q_ren", 64'(bus.q_ren), 64'h0);
        chk("arst_valid", 64'(bus.out_valid), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        reset_model();
        step(0, 1, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("post_rst_left", 64'(qm.size()), 64'h2);
        if (qm.size() == 2) begin
            chk("post_rst_w2", 64'(qm[0]), 64'(w[2]));
            chk("post_rst_w3", 64'(qm[1]), 64'(w[3]));
        end

        // Two-word flush then two bursts: 10 pops, 2 bursts since reset.
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) load(DATA'({$urandom(), $urandom()}));
            for (int i = 0; i < 8; i++) step(0, 1, 0);
        end
`ifdef QUEUE_READER_STATS_EN
        chk("stats_pops", 64'(pop_count), 64'd10);
        chk("stats_bursts", 64'(burst_count), 64'd2);
`endif

        // Random traffic, backpressure and flushes against the model.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2));
        step(1, 1, 0);
        for (int i = 0; i < 80; i++) step(0, 1, 0);
        chk("final_drained", 64'(qm.size()), 64'h0);
        chk("final_idle", 64'(busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
